sccb_cfg_sequencer: RTL and testbench

- Sequencer that walks the camera register-configuration LUT (index → {reg_addr, reg_data}) and drives the I2C/SCCB master core.
- Order: power-up wait, then ID reads for the first READ_CNT entries, then writes for all remaining entries.
- Applies a settle delay after the soft-reset write (reg 0x12 = 0x80).
- Sits between the LUT module and the I2C master; reports done/error status to the video pipeline's enable logic.

---
 rtl/sccb_cfg_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_sccb_cfg_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_sequencer.sv
// Walks the camera register LUT and drives the SCCB/I2C master: power-up wait, ID reads, then writes.
// Optional write readback verification is enabled with `define SCCB_CFG_READBACK_EN.
module sccb_cfg_sequencer #(
  parameter logic [23:0] POWERUP_DLY = 24'd1_000_000,
  parameter logic [23:0] SWRESET_DLY = 24'd250_000,
  parameter logic [7:0]  READ_CNT    = 8'd2,
  parameter logic [3:0]  MAX_RETRY   = 4'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_restart,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  input  logic [7:0]  lut_size,
  output logic        i2c_req,
  output logic        i2c_rw,
  output logic [7:0]  i2c_addr,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  input  logic [7:0]  i2c_rdata,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        id_mismatch
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    ISSUE,
    WAIT,
    SW_WAIT,
    NEXT,
    DONE,
    ERROR
`ifdef SCCB_CFG_READBACK_EN
    , VERIFY
`endif
  } state_t;

  state_t      state;
  logic [23:0] dly_cnt;
  logic [3:0]  retry;
  logic [7:0]  next_index;
  logic        pwr_expired;
  logic        sw_expired;
  logic        is_swreset;
  logic        retry_left;
  logic        txn_fail;
`ifdef SCCB_CFG_READBACK_EN
  logic        verifying;
`endif

  assign next_index  = lut_index + 8'd1;
  assign pwr_expired = (dly_cnt + 24'd1) >= POWERUP_DLY;
  assign sw_expired  = (dly_cnt + 24'd1) >= SWRESET_DLY;
  assign is_swreset  = !i2c_rw && ({i2c_addr, i2c_wdata} == 16'h1280);
  assign retry_left  = retry < MAX_RETRY;

  // A readback that disagrees with the written byte is handled exactly like a NACK.
  always_comb begin
    txn_fail = i2c_nack;
`ifdef SCCB_CFG_READBACK_EN
    if (verifying && (i2c_rdata != i2c_wdata)) txn_fail = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PWR_WAIT;
      dly_cnt     <= '0;
      retry       <= '0;
      lut_index   <= '0;
      i2c_req     <= 1'b0;
      i2c_rw      <= 1'b0;
      i2c_addr    <= '0;
      i2c_wdata   <= '0;
      cfg_busy    <= 1'b1;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      id_mismatch <= 1'b0;
`ifdef SCCB_CFG_READBACK_EN
      verifying   <= 1'b0;
`endif
    end else begin
      case (state)
        PWR_WAIT: begin
          if (pwr_expired) begin
            dly_cnt <= '0;
            if (lut_size == 8'd0) begin
              state    <= DONE;
              cfg_busy <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end else begin
            dly_cnt <= dly_cnt + 24'd1;
          end
        end
        ISSUE: begin
          i2c_addr  <= lut_data[15:8];
          i2c_wdata <= lut_data[7:0];
          i2c_rw    <= (lut_index < READ_CNT);
          i2c_req   <= 1'b1;
          state     <= WAIT;
`ifdef SCCB_CFG_READBACK_EN
          verifying <= 1'b0;
`endif
        end
        WAIT: begin
          if (i2c_done) begin
            i2c_req <= 1'b0;
            if (txn_fail) begin
              if (retry_left) begin
                retry <= retry + 4'd1;
                state <= ISSUE;
              end else begin
                state    <= ERROR;
                cfg_busy <= 1'b0;
                cfg_err  <= 1'b1;
              end
            end
`ifdef SCCB_CFG_READBACK_EN
            else if (verifying) begin
              state <= NEXT;
            end
`endif
            else if (i2c_rw) begin
              if (i2c_rdata != lut_data[7:0]) id_mismatch <= 1'b1;
              state <= NEXT;
            end else if (is_swreset) begin
              state <= SW_WAIT;
            end else begin
`ifdef SCCB_CFG_READBACK_EN
              state <= VERIFY;
`else
              state <= NEXT;
`endif
            end
          end
        end
`ifdef SCCB_CFG_READBACK_EN
        VERIFY: begin
          // Same address and data fields are kept; only the direction flips to read.
          i2c_rw    <= 1'b1;
          i2c_req   <= 1'b1;
          verifying <= 1'b1;
          state     <= WAIT;
        end
`endif
        SW_WAIT: begin
          if (sw_expired) begin
            dly_cnt <= '0;
            state   <= NEXT;
          end else begin
            dly_cnt <= dly_cnt + 24'd1;
          end
        end
        NEXT: begin
          retry     <= '0;
          lut_index <= next_index;
          if (next_index == lut_size) begin
            state    <= DONE;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b1;
          end else begin
            state <= ISSUE;
          end
        end
        DONE, ERROR: begin
          if (cfg_restart) begin
            id_mismatch <= 1'b0;
            lut_index   <= '0;
            retry       <= '0;
            dly_cnt     <= '0;
            cfg_busy    <= 1'b1;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            state       <= PWR_WAIT;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Randomized bench for sccb_cfg_sequencer: a bus-master model answers requests and an entry-level
// reference model predicts the ordered transaction list, request gaps and final status.
`timescale 1ns/1ps
module tb_sccb_cfg_sequencer;

  localparam logic [23:0] PDLY = 24'd16;
  localparam logic [23:0] SDLY = 24'd8;
  localparam logic [7:0]  RCNT = 8'd2;
  localparam logic [3:0]  MAXR = 4'd3;
`ifdef SCCB_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] gap;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_restart = 1'b0;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic [7:0]  lut_size = 8'd0;
  logic        i2c_req, i2c_rw;
  logic [7:0]  i2c_addr, i2c_wdata;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic [7:0]  i2c_rdata = 8'h00;
  logic        cfg_busy, cfg_done, cfg_err, id_mismatch;

  logic [15:0] lut [256];
  int          nack_plan [256];
  int          corr_plan [256];
  int          nack_left [256];
  int          corr_left [256];
  logic [7:0]  id_resp [2];
  logic [7:0]  last_wdata;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   exp_err, exp_mism, exp_idx;
  int   cyc = 0;
  int   last_done_cyc = 0;
  logic prev_req = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  assign lut_data = lut[lut_index];

  sccb_cfg_sequencer #(
    .POWERUP_DLY(PDLY),
    .SWRESET_DLY(SDLY),
    .READ_CNT(RCNT),
    .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_restart(cfg_restart),
    .lut_index(lut_index), .lut_data(lut_data), .lut_size(lut_size),
    .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .id_mismatch(id_mismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Request monitor: every rising i2c_req is logged with its distance from the last completion.
  always @(negedge clk) begin
    if (i2c_req && !prev_req)
      obs_q.push_back(txn_t'{i2c_rw, i2c_addr, i2c_wdata, 16'(cyc - last_done_cyc)});
    prev_req <= i2c_req;
  end

  // Bus-master model with random response latency.
  initial begin
    int m_idx;
    forever begin
      @(negedge clk);
      if (rst_n && i2c_req) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(posedge clk); #1;
        if (rst_n && i2c_req) begin
          m_idx = int'(lut_index);
          i2c_nack = 1'b0;
          i2c_rdata = 8'($urandom);
          if (nack_left[m_idx] > 0) begin
            nack_left[m_idx]--;
            i2c_nack = 1'b1;
          end else if (i2c_rw) begin
            if (m_idx < int'(RCNT)) i2c_rdata = id_resp[m_idx];
            else begin
              i2c_rdata = last_wdata;
              if (corr_left[m_idx] > 0) begin
                corr_left[m_idx]--;
                i2c_rdata = i2c_rdata ^ 8'h01;
              end
            end
          end else begin
            last_wdata = i2c_wdata;
          end
          i2c_done = 1'b1;
          last_done_cyc = cyc;
          @(posedge clk); #1;
          i2c_done = 1'b0;
          i2c_nack = 1'b0;
        end
      end
    end
  end

  // Reference: per-entry retry loop producing the expected request list and final status.
  task automatic build_model();
    int gap = 17;
    exp_q.delete();
    exp_err = 0; exp_mism = 0; exp_idx = int'(lut_size);
    for (int i = 0; i < int'(lut_size); i++) begin
      logic [15:0] e = lut[i];
      bit rd = (i < int'(RCNT));
      int tries = 0;
      int nk = nack_plan[i];
      int cr = corr_plan[i];
      bit ok = 1'b0;
      while (!ok) begin
        bit fail = 1'b0;
        exp_q.push_back(txn_t'{rd, e[15:8], e[7:0], 16'(gap)});
        gap = 2;
        if (nk > 0) begin nk--; fail = 1'b1; end
        else if (rd) begin
          if (id_resp[i] != e[7:0]) exp_mism = 1;
          ok = 1'b1;
        end else if (e == 16'h1280 || !RB) ok = 1'b1;
        else begin
          exp_q.push_back(txn_t'{1'b1, e[15:8], e[7:0], 16'd2});
          if (cr > 0) begin cr--; fail = 1'b1; end
          else ok = 1'b1;
        end
        if (fail) begin
          if (tries == int'(MAXR)) begin
            exp_err = 1; exp_idx = i;
            return;
          end
          tries++;
        end
      end
      gap = (!rd && e == 16'h1280) ? 11 : 3;
    end
  endtask

  task automatic fill_lut(input int size);
    lut_size = 8'(size);
    for (int i = 0; i < 256; i++) begin
      lut[i] = 16'($urandom);
      if (lut[i] == 16'h1280) lut[i][0] = 1'b1;
      if (lut[i][15:8] == 8'h3d) lut[i][8] = 1'b0;
      nack_plan[i] = 0;
      corr_plan[i] = 0;
    end
    lut[0] = {8'h0A, 8'h7F};
    lut[1] = {8'h0B, 8'hA2};
    id_resp[0] = 8'h7F;
    id_resp[1] = 8'hA2;
  endtask

  task automatic arm_master();
    for (int i = 0; i < 256; i++) begin
      nack_left[i] = nack_plan[i];
      corr_left[i] = corr_plan[i];
    end
    last_wdata = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    arm_master();
    obs_q.delete();
    rst_n = 1'b1;
    last_done_cyc = cyc;
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1;
    arm_master();
    obs_q.delete();
    cfg_restart = 1'b1;
    last_done_cyc = cyc + 1;
    @(posedge clk); #1;
    cfg_restart = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (cfg_busy && n < 8000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (cfg_busy) begin
      n_fail++;
      $display("FAIL %s_timeout: cfg_busy=1 after %0d cycles, required 0", name, n);
    end
  endtask

  // Compares the logged run against the reference model's prediction.
  task automatic finish_run(input string name);
    int n;
    wait_idle(name);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d requests, required %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_txn%0d: got rw=%0b addr=%h data=%h gap=%0d, required rw=%0b addr=%h data=%h gap=%0d",
                 name, i, obs_q[i].rw, obs_q[i].addr, obs_q[i].wdata, obs_q[i].gap,
                 exp_q[i].rw, exp_q[i].addr, exp_q[i].wdata, exp_q[i].gap);
      end
    end
    n_chk++;
    if ({cfg_done, cfg_err, cfg_busy, i2c_req} !== {exp_err == 0, exp_err == 1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_status: got done/err/busy/req=%b, required %b", name,
               {cfg_done, cfg_err, cfg_busy, i2c_req}, {exp_err == 0, exp_err == 1, 1'b0, 1'b0});
    end
    n_chk++;
    if (lut_index !== 8'(exp_idx)) begin
      n_fail++;
      $display("FAIL %s_index: got %0d, required %0d", name, lut_index, exp_idx);
    end
    n_chk++;
    if (id_mismatch !== 1'(exp_mism)) begin
      n_fail++;
      $display("FAIL %s_id_mismatch: got %b, required %0d", name, id_mismatch, exp_mism);
    end
  endtask

  task automatic test_reset();
    fill_lut(4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({lut_index, i2c_req, i2c_rw, i2c_addr, i2c_wdata} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_cmd: got idx=%h req=%b rw=%b addr=%h data=%h, required all zero",
               lut_index, i2c_req, i2c_rw, i2c_addr, i2c_wdata);
    end
    n_chk++;
    if ({cfg_busy, cfg_done, cfg_err, id_mismatch} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_status: got busy/done/err/mism=%b, required 1000",
               {cfg_busy, cfg_done, cfg_err, id_mismatch});
    end
  endtask

  task automatic test_full_sequence();
    fill_lut(70);
    build_model();
    do_reset();
    repeat (60) @(posedge clk);
    #1 cfg_restart = 1'b1;
    @(posedge clk);
    #1 cfg_restart = 1'b0;
    finish_run("full70");
  endtask

  task automatic test_id_mismatch();
    fill_lut(20);
    id_resp[1] = 8'hA3;
    build_model();
    do_reset();
    finish_run("idmis");
    id_resp[1] = 8'hA2;
    build_model();
    pulse_restart();
    @(negedge clk);
    n_chk++;
    if ({id_mismatch, lut_index, cfg_busy, cfg_done} !== {1'b0, 8'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_clear: got mism=%b idx=%0d busy=%b done=%b, required 0 0 1 0",
               id_mismatch, lut_index, cfg_busy, cfg_done);
    end
    finish_run("idmis_rerun");
  endtask

  task automatic test_swreset();
    fill_lut(10);
    lut[2] = 16'h1280;
    build_model();
    do_reset();
    finish_run("swreset");
  endtask

  task automatic test_nack_retry();
    int cnt = 0;
    fill_lut(12);
    lut[5] = {8'h3d, 8'h5A};
    nack_plan[5] = 3;
    build_model();
    do_reset();
    finish_run("nack3");
    foreach (obs_q[i]) if (obs_q[i].addr == 8'h3d && !obs_q[i].rw) cnt++;
    n_chk++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL nack3_writes: got %0d writes to 3d, required 4", cnt);
    end
    nack_plan[5] = 4;
    build_model();
    do_reset();
    finish_run("nack4_err");
  endtask

  task automatic test_mid_reset();
    int n = 0;
    fill_lut(40);
    build_model();
    do_reset();
    @(negedge clk);
    while (!(lut_index == 8'd30 && i2c_req) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!(lut_index == 8'd30 && i2c_req)) begin
      n_fail++;
      $display("FAIL midrst_reach: index 30 request not seen, got idx=%0d req=%b", lut_index, i2c_req);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({i2c_req, lut_index, cfg_busy} !== {1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_async: got req=%b idx=%0d busy=%b, required 0 0 1", i2c_req, lut_index, cfg_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    arm_master();
    obs_q.delete();
    rst_n = 1'b1;
    last_done_cyc = cyc;
    finish_run("midrst_rerun");
  endtask

  task automatic test_edge_sizes();
    for (int s = 0; s < 3; s++) begin
      fill_lut(s);
      build_model();
      do_reset();
      finish_run($sformatf("size%0d", s));
    end
  endtask

  task automatic test_readback();
    fill_lut(8);
    lut[3] = {8'h0C, 8'hD0};
    corr_plan[3] = 1;
    lut[5] = 16'h1280;
    build_model();
    do_reset();
    finish_run("readback");
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int size = $urandom_range(3, 30);
      fill_lut(size);
      if ($urandom_range(0, 1) == 1) lut[$urandom_range(2, size - 1)] = 16'h1280;
      if ($urandom_range(0, 2) == 0) id_resp[$urandom_range(0, 1)] = 8'($urandom);
      for (int i = 0; i < size; i++) begin
        if ($urandom_range(0, 6) == 0) nack_plan[i] = $urandom_range(1, 4);
        if ($urandom_range(0, 5) == 0) corr_plan[i] = $urandom_range(1, 2);
      end
      build_model();
      do_reset();
      finish_run($sformatf("rand%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_id_mismatch();
    test_swreset();
    test_nack_retry();
    test_mid_reset();
    test_edge_sizes();
    test_readback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
